// File: rtl/seq_divider.sv
// Multi-cycle restoring unsigned divider: one quotient bit per clock,
// results held from the done pulse until the next completed operation.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   prem;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             neg;
  logic [WIDTH:0]   prem_new;
  logic [WIDTH-1:0] dvd_new;

  // One extra guard bit on the difference so the borrow is always visible.
  always_comb begin
    shifted  = {prem[WIDTH-1:0], dvd[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, dvs};
    neg      = diff[WIDTH+1];
    prem_new = neg ? shifted : diff[WIDTH:0];
    dvd_new  = {dvd[WIDTH-2:0], ~neg};
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = (b == '0) ? DONE : RUN;
        else       state_next = IDLE;
      end
      RUN:     state_next = (cnt == CW'(1)) ? DONE : RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dvd   <= '0;
      dvs   <= '0;
      prem  <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (b != '0) begin
              dvd  <= a;
              dvs  <= b;
              prem <= '0;
              cnt  <= CW'(WIDTH);
            end else begin
              q   <= '1;
              r   <= a;
              dbz <= 1'b1;
            end
          end
        end
        RUN: begin
          dvd  <= dvd_new;
          prem <= prem_new;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            q   <= dvd_new;
            r   <= prem_new[WIDTH-1:0];
            dbz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
